// File: rtl/muldiv_sequencer_if.sv
// Bundle of the EX-side issue/read signals and the arithmetic-core start/done
// handshake. The slave side is the sequencer; the master side is whoever
// drives EX operands and plays the arithmetic core.
interface muldiv_sequencer_if;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        id_uses_md;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        core_start;
    logic        core_signed;
    logic        core_is_div;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        err;

    modport slave (
        input  op, src_a, src_b, id_uses_md, rd_sel, core_done, core_hi, core_lo,
        output rd_data, busy, stall, core_start, core_signed, core_is_div,
               core_a, core_b, err
    );

    modport master (
        output op, src_a, src_b, id_uses_md, rd_sel, core_done, core_hi, core_lo,
        input  rd_data, busy, stall, core_start, core_signed, core_is_div,
               core_a, core_b, err
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: accepts md-class ops from EX, launches them on an
// external arithmetic core, owns HI/LO and raises the ID-stage stall while the
// shared resource is occupied.
module muldiv_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_sequencer_if.slave  md
);
    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [31:0]     hi_reg;
    logic [31:0]     lo_reg;
    logic [31:0]     a_reg;
    logic [31:0]     b_reg;
    logic            signed_reg;
    logic            is_div_reg;
    logic            err_reg;
    logic [CW-1:0]   cnt_reg;

    logic            is_md_op;
    logic            is_div_op;
    logic            is_move_op;
    logic            accept;
    logic            done_hit;
    logic            timeout_hit;
    logic            violation;

    // Op decode; reserved op 7 decodes as nothing so it behaves like NONE.
    assign is_md_op    = (md.op >= 3'd1) && (md.op <= 3'd4);
    assign is_div_op   = (md.op == 3'd3) || (md.op == 3'd4);
    assign is_move_op  = (md.op == 3'd5) || (md.op == 3'd6);
    // A divide by zero is silently refused: no launch and no error.
    assign accept      = (state_reg == S_IDLE) && is_md_op && !(is_div_op && (md.src_b == 32'd0));
    assign done_hit    = (state_reg == S_WAIT) && md.core_done;
    // A done arriving on the final allowed cycle beats the timeout.
    assign timeout_hit = (state_reg == S_WAIT) && !md.core_done && (cnt_reg == CNT_LAST);
    // Any real op arriving while occupied is dropped and flagged.
    assign violation   = (state_reg != S_IDLE) && (is_md_op || is_move_op);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: IDLE -> LAUNCH on accept, one LAUNCH cycle, then WAIT
    // until the core answers or the timeout expires.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (done_hit || timeout_hit) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Operand latch: held stable for the whole LAUNCH/WAIT occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            is_div_reg <= 1'b0;
        end else if (accept) begin
            a_reg      <= md.src_a;
            b_reg      <= md.src_b;
            signed_reg <= (md.op == 3'd1) || (md.op == 3'd3);
            is_div_reg <= is_div_op;
        end
    end

    // HI/LO: core result capture in WAIT, direct moves only while IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (done_hit) begin
            hi_reg <= md.core_hi;
            lo_reg <= md.core_lo;
        end else if ((state_reg == S_IDLE) && (md.op == 3'd5)) begin
            hi_reg <= md.src_a;
        end else if ((state_reg == S_IDLE) && (md.op == 3'd6)) begin
            lo_reg <= md.src_a;
        end
    end

    // WAIT cycle counter; cleared whenever not waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                      cnt_reg <= '0;
        else if ((state_reg == S_WAIT) && !md.core_done && !timeout_hit) cnt_reg <= cnt_reg + 1'b1;
        else                                                            cnt_reg <= '0;
    end

    // Sticky error flag: timeout or issue while occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         err_reg <= 1'b0;
        else if (timeout_hit || violation) err_reg <= 1'b1;
    end

    assign md.busy        = (state_reg != S_IDLE);
    assign md.core_start  = (state_reg == S_LAUNCH);
    assign md.stall       = md.id_uses_md && (md.busy || accept);
    assign md.rd_data     = md.rd_sel ? hi_reg : lo_reg;
    assign md.core_a      = a_reg;
    assign md.core_b      = b_reg;
    assign md.core_signed = signed_reg;
    assign md.core_is_div = is_div_reg;
    assign md.err         = err_reg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver plays EX and the
// arithmetic core, pushes expected per-cycle outputs and expected launches
// into queues; a monitor pops and compares them at the falling edge.
module tb_muldiv_sequencer;
    localparam int TIMEOUT   = 4;
    localparam int SIG_RD    = 0;
    localparam int SIG_BUSY  = 1;
    localparam int SIG_STALL = 2;
    localparam int SIG_ERR   = 3;
    localparam int SIG_START = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        dv;
    } launch_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_err = 1'b0;
    chk_t        chk_q[$];
    launch_t     launch_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(input int s);
        case (s)
            SIG_RD:    return bus.rd_data;
            SIG_BUSY:  return 32'(bus.busy);
            SIG_STALL: return 32'(bus.stall);
            SIG_ERR:   return 32'(bus.err);
            SIG_START: return 32'(bus.core_start);
            default:   return 32'd0;
        endcase
    endfunction

    // Reference results straight from the arithmetic definitions.
    function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd1: begin
                p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd2: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            3'd3: begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
            3'd4: begin
                lo = a / b;
                hi = a % b;
            end
            default: ;
        endcase
    endfunction

    task automatic expect_v(input int s, input logic [31:0] v, input string nm);
        chk_t c;
        c.cyc  = cyc;
        c.sig  = s;
        c.exp  = v;
        c.name = nm;
        chk_q.push_back(c);
    endtask

    task automatic check_rd(input string nm);
        expect_v(SIG_RD, bus.rd_sel ? m_hi : m_lo, nm);
    endtask

    // Monitor: per-cycle expectations plus the launch scoreboard.
    initial begin
        chk_t        c;
        launch_t     l;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                c   = chk_q.pop_front();
                act = get_sig(c.sig);
                n_checks++;
                if (act !== c.exp) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h", c.name, cyc, act, c.exp);
                end
            end
            if (bus.core_start === 1'b1) begin
                n_checks++;
                if (launch_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL launch_unexpected cyc=%0d actual=start required=no_start", cyc);
                end else begin
                    l = launch_q.pop_front();
                    if (bus.core_a !== l.a || bus.core_b !== l.b ||
                        bus.core_signed !== l.sgn || bus.core_is_div !== l.dv) begin
                        n_errors++;
                        $display("FAIL launch_operands cyc=%0d actual=%h/%h/s%b/d%b required=%h/%h/s%b/d%b",
                                 cyc, bus.core_a, bus.core_b, bus.core_signed, bus.core_is_div,
                                 l.a, l.b, l.sgn, l.dv);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.op         = 3'd0;
        bus.core_done  = 1'b0;
        bus.id_uses_md = 1'($urandom_range(0, 1));
        bus.rd_sel     = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_checks();
        expect_v(SIG_BUSY,  32'd0, "idle_busy");
        expect_v(SIG_STALL, 32'd0, "idle_stall");
        expect_v(SIG_START, 32'd0, "idle_start");
        expect_v(SIG_ERR,   32'(m_err), "idle_err");
        check_rd("idle_rd");
    endtask

    task automatic idle_cycle();
        next_cycle();
        idle_checks();
    endtask

    task automatic do_move(input logic [2:0] op, input logic [31:0] v);
        next_cycle();
        bus.op    = op;
        bus.src_a = v;
        bus.src_b = $urandom;
        idle_checks();
        if (op == 3'd5) m_hi = v;
        else            m_lo = v;
        $display("move op=%0d val=%h", op, v);
        // Read back the register just written on the very next cycle.
        next_cycle();
        bus.rd_sel = (op == 3'd5);
        idle_checks();
    endtask

    // k: WAIT cycle (1..TIMEOUT) carrying core_done, 0 = core never answers.
    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input bit viol);
        logic [31:0] rh;
        logic [31:0] rl;
        logic        acc;
        launch_t     l;
        int          n;
        acc = !(((op == 3'd3) || (op == 3'd4)) && (b == 32'd0));
        next_cycle();
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        expect_v(SIG_BUSY,  32'd0, "issue_busy");
        expect_v(SIG_STALL, 32'(bus.id_uses_md & acc), "issue_stall");
        expect_v(SIG_START, 32'd0, "issue_start");
        expect_v(SIG_ERR,   32'(m_err), "issue_err");
        check_rd("issue_rd");
        if (!acc) begin
            $display("md op=%0d a=%h b=%h refused (divide by zero)", op, a, b);
            next_cycle();
            idle_checks();
            return;
        end
        calc(op, a, b, rh, rl);
        l = '{a, b, (op == 3'd1) || (op == 3'd3), (op == 3'd3) || (op == 3'd4)};
        launch_q.push_back(l);
        next_cycle();
        if (viol) begin
            bus.op    = 3'd5;
            bus.src_a = $urandom;
        end
        expect_v(SIG_START, 32'd1, "launch_start");
        expect_v(SIG_BUSY,  32'd1, "launch_busy");
        expect_v(SIG_STALL, 32'(bus.id_uses_md), "launch_stall");
        expect_v(SIG_ERR,   32'(m_err), "launch_err");
        check_rd("launch_rd");
        if (viol) m_err = 1'b1;
        n = (k == 0) ? TIMEOUT : k;
        for (int j = 1; j <= n; j++) begin
            next_cycle();
            bus.core_hi = $urandom;
            bus.core_lo = $urandom;
            if (j == k) begin
                bus.core_done = 1'b1;
                bus.core_hi   = rh;
                bus.core_lo   = rl;
            end
            expect_v(SIG_BUSY,  32'd1, "wait_busy");
            expect_v(SIG_START, 32'd0, "wait_start");
            expect_v(SIG_STALL, 32'(bus.id_uses_md), "wait_stall");
            expect_v(SIG_ERR,   32'(m_err), "wait_err");
            check_rd("wait_rd");
        end
        if (k != 0) begin
            m_hi = rh;
            m_lo = rl;
        end else begin
            m_err = 1'b1;
        end
        $display("md op=%0d a=%h b=%h done_at=%0d viol=%0d -> hi=%h lo=%h err=%0d",
                 op, a, b, k, viol, m_hi, m_lo, m_err);
        next_cycle();
        idle_checks();
        next_cycle();
        bus.rd_sel = ~bus.rd_sel;
        idle_checks();
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          r;
        launch_t     l;

        bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus.id_uses_md = 1'b0; bus.rd_sel = 1'b0;
        bus.core_done = 1'b0; bus.core_hi = 32'd0; bus.core_lo = 32'd0;

        // Reset state.
        repeat (2) idle_cycle();
        next_cycle();
        reset = 1'b0;
        idle_checks();
        $display("reset released");

        // Directed: signed -1 * 2.
        do_md(3'd1, 32'hFFFFFFFF, 32'd2, 3, 1'b0);
        // Directed: DIVU by zero is refused.
        do_md(3'd4, 32'd7, 32'd0, 1, 1'b0);
        // Directed: moves.
        do_move(3'd6, 32'h12345678);
        do_move(3'd5, 32'hCAFEF00D);

        // Randomized traffic, every launch answered in time.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3 || r == 9) begin
                rop = 3'($urandom_range(1, 4));
                ra  = $urandom;
                rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
                do_md(rop, ra, rb, $urandom_range(1, TIMEOUT), 1'b0);
            end else if (r == 4 || r == 5) begin
                do_move(3'(r + 1), $urandom);
            end else if (r == 6 || r == 7) begin
                next_cycle();
                bus.op = (r == 7) ? 3'd7 : 3'd0;
                idle_checks();
                $display("idle op=%0d", bus.op);
            end else begin
                next_cycle();
                bus.core_done = 1'b1;
                bus.core_hi   = $urandom;
                bus.core_lo   = $urandom;
                idle_checks();
                $display("stray core_done in IDLE");
                idle_cycle();
            end
        end

        // Timeout: core never answers.
        do_md(3'd2, $urandom, $urandom, 0, 1'b0);

        // Reset in the middle of WAIT, then a late done that must be ignored.
        next_cycle();
        ra = $urandom; rb = $urandom;
        bus.op = 3'd1; bus.src_a = ra; bus.src_b = rb;
        l = '{ra, rb, 1'b1, 1'b0};
        launch_q.push_back(l);
        next_cycle();
        expect_v(SIG_START, 32'd1, "rstw_launch_start");
        next_cycle();
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
        idle_checks();
        next_cycle();
        reset = 1'b0;
        bus.core_done = 1'b1;
        bus.core_hi = $urandom;
        bus.core_lo = $urandom;
        idle_checks();
        $display("reset during WAIT, late done");
        next_cycle();
        bus.rd_sel = 1'b1;
        idle_checks();
        next_cycle();
        bus.rd_sel = 1'b0;
        idle_checks();

        // Done on the last allowed WAIT cycle wins over the timeout.
        do_md(3'd3, 32'hFFFFFF9C, 32'd7, TIMEOUT, 1'b0);

        // Protocol violation: MTHI while occupied is dropped and flagged.
        do_md(3'd2, $urandom, $urandom, 2, 1'b1);
        repeat (2) idle_cycle();

        @(negedge clk);
        #1;
        n_checks++;
        if (launch_q.size() != 0 || chk_q.size() != 0) begin
            n_errors++;
            $display("FAIL queues_drained actual=%0d/%0d required=0/0", launch_q.size(), chk_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequencing controller for the shared multiply/divide resource that the EX stage feeds. It accepts one mult/div/mthi/mtlo operation per issue from EX and launches multi-cycle multiply/divide operations on an external arithmetic core with a start/done handshake. It owns the architectural HI/LO registers and generates the ID-stage stall for any md-class instruction while the resource is occupied.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT before abort (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
op  input  3  EX-stage md op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
src_a  input  32  rs value (forwarded)
src_b  input  32  rt value (forwarded)
id_uses_md  input  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
rd_sel  input  1  0 selects LO, 1 selects HI on rd_data
rd_data  output  32  combinational read of HI or LO register
busy  output  1  resource occupied (state LAUNCH or WAIT)
stall  output  1  freeze PC/IF-ID, bubble into EX
core_start  output  1  one-cycle launch pulse to arithmetic core
core_signed  output  1  signed operation
core_is_div  output  1  1 divide, 0 multiply
core_a  output  32  latched operand A
core_b  output  32  latched operand B
core_done  input  1  core result valid (single-cycle pulse)
core_hi  input  32  result high word / remainder
core_lo  input  32  result low word / quotient
err  output  1  sticky error flag

Behaviour:
- Reset (async, any state): state IDLE; HI=LO=0; core_a=core_b=0; core_signed=core_is_div=0; timeout counter 0; err=0. Outputs follow: busy=0, core_start=0, stall=0 unless combinational inputs demand.
- States: IDLE, LAUNCH, WAIT.
- IDLE, op in {1..4} at cycle T: latch src_a/src_b, signed (op 1,3) and is_div (op 3,4); next state LAUNCH.
- Divide-by-zero: IDLE, op DIV/DIVU with src_b==0: no launch, state stays IDLE, HI/LO unchanged, err unchanged.
- IDLE, op MTHI/MTLO: write src_a into HI/LO at edge ending T; no busy. A read in cycle T+1 returns the new value.
- LAUNCH (T+1): core_start=1 for exactly this cycle; busy=1; next state WAIT; counter cleared.
- WAIT: busy=1; core_a/b/signed/is_div held stable. On core_done: HI<=core_hi, LO<=core_lo at that edge; next state IDLE; busy=0 the following cycle.
- Timeout: counter increments each WAIT cycle without core_done; when counter reaches TIMEOUT-1 without done, return to IDLE, HI/LO unchanged, err<=1 (sticky until reset). core_done in that same cycle wins: result captured, no error.
- core_done outside WAIT: ignored.
- op != NONE while state != IDLE: operation dropped, err<=1 (stall must prevent this; protocol violation).
- stall = id_uses_md AND (busy OR (state==IDLE AND op in {1..4} AND accepted)). Non-md instructions never stall.
- rd_data = rd_sel ? HI : LO, pure combinational, no bypass of in-flight results (stall guarantees ordering).
- Min mult/div occupancy: accept T, launch T+1, earliest done T+2, HI/LO valid for read from T+3.

Test Plan:
- Reset mid-WAIT (after MULT issued) -> next cycle busy=0, HI=LO=0, err=0; subsequent core_done ignored.
- MULT src_a=0xFFFFFFFF src_b=2, core returns hi=0xFFFFFFFF lo=0xFFFFFFFE after 3 WAIT cycles -> core_start single pulse at T+1, core_signed=1, busy high T+1..T+4, rd_sel=1 reads 0xFFFFFFFF afterwards.
- DIVU 7/0 in IDLE -> no core_start, busy stays 0, HI/LO unchanged, stall=0 with id_uses_md=1.
- MTLO 0x12345678 then MFLO next cycle -> rd_data=0x12345678, no stall.
- id_uses_md=1 while DIV in WAIT -> stall=1 every cycle until cycle after core_done; id_uses_md=0 -> stall=0 throughout.
- TIMEOUT=4, no core_done -> return to IDLE after 4 WAIT cycles, err=1, HI/LO unchanged; repeat with done on the 4th cycle -> result captured, err=0.
